// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: each instruction walks FETCH/DECODE/EXEC/MEM/WB
// over one req/ready memory port that is shared by instruction fetch and data access.
//   state  | meaning
//   FETCH  | read instruction at pc into IR
//   DECODE | read operands, pc += 4, trap illegal encodings
//   EXEC   | ALU result, effective address, branch or jump
//   MEM    | load or store through the shared port
//   WB     | register-file write
//   HALT   | illegal instruction seen; parked until reset
module mips_multicycle_core #(
    parameter int          NREGS    = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);

    localparam int RW = $clog2(NREGS);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0]       r_regs [NREGS];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic [31:0] w_sext, w_pc32, w_br, w_jt, w_ea, w_alu, w_wr_data;
    logic        w_is_r, w_is_j, w_is_beq, w_is_addi, w_is_lw, w_is_sw;
    logic        w_funct_ok, w_rs_bad, w_rt_bad, w_rd_bad, w_illegal;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_is_r    = (w_op == OP_R);
    assign w_is_j    = (w_op == OP_J);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);

    assign w_funct_ok = (w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND) ||
                        (w_funct == F_OR)  || (w_funct == F_SLT);
    assign w_rs_bad   = ({1'b0, w_rs} >= 6'(NREGS));
    assign w_rt_bad   = ({1'b0, w_rt} >= 6'(NREGS));
    assign w_rd_bad   = ({1'b0, w_rd} >= 6'(NREGS));

    always_comb begin
        w_illegal = 1'b1;
        if (w_is_r)
            w_illegal = !w_funct_ok || w_rs_bad || w_rt_bad || w_rd_bad;
        else if (w_is_addi || w_is_lw || w_is_sw || w_is_beq)
            w_illegal = w_rs_bad || w_rt_bad;
        else if (w_is_j)
            w_illegal = 1'b0;
    end

    // Branch/jump targets are formed at 32 bits, then truncated to the PC width.
    assign w_pc32 = 32'(r_pc);
    assign w_br   = w_pc32 + (w_sext << 2);
    assign w_jt   = {w_pc32[31:28], r_ir[25:0], 2'b00};
    assign w_ea   = (r_a + w_sext) & 32'hFFFF_FFFC;

    always_comb begin
        w_alu = '0;
        if (w_is_addi) begin
            w_alu = r_a + w_sext;
        end else begin
            case (w_funct)
                F_ADD:   w_alu = r_a + r_b;
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
                default: w_alu = '0;
            endcase
        end
    end

    assign w_dst     = w_is_r ? w_rd : w_rt;
    assign w_wr_data = w_is_lw ? r_mdr : r_alu;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_is_r || w_is_addi) begin
                    w_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = w_is_sw;
                mem_addr  = r_alu[ADDR_W-1:0];
                mem_wdata = w_is_sw ? r_b : 32'h0;
                if (mem_ready) begin
                    retire = w_is_sw;
                    w_next = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // Reset abandons any access in flight within the same cycle.
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            retire    = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC[ADDR_W-1:0];
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_mdr <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) r_ir <= mem_rdata;
                S_DECODE: begin
                    r_a  <= r_regs[w_rs[RW-1:0]];
                    r_b  <= r_regs[w_rt[RW-1:0]];
                    r_pc <= r_pc + ADDR_W'(4);
                end
                S_EXEC: begin
                    if (w_is_r || w_is_addi) begin
                        r_alu <= w_alu;
                    end else if (w_is_lw || w_is_sw) begin
                        r_alu <= w_ea;
                    end else if (w_is_beq) begin
                        if (r_a == r_b) r_pc <= w_br[ADDR_W-1:0];
                    end else begin
                        r_pc <= w_jt[ADDR_W-1:0];
                    end
                end
                S_MEM: if (mem_ready && w_is_lw) r_mdr <= mem_rdata;
                S_WB: if (w_dst != 5'd0) r_regs[w_dst[RW-1:0]] <= w_wr_data;
                default: ;
            endcase
        end
    end

    assign pc = r_pc;

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle successor to the single-cycle MIPS datapath. It runs one instruction through a FETCH/DECODE/EXEC/MEM/WB state machine and shares a single external memory port between instruction fetch and data access. That port uses a req/ready handshake, so wait-state memories are supported. Register-file depth, address width and reset vector are parameters, and a halt state catches illegal instructions.

## Interface

Parameters:
- NREGS, 32: architectural registers; 8, 16 or 32; r0 reads zero.
- ADDR_W, 32: byte-address width of PC and memory port; 8..32.
- RESET_PC, 0: PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
- mem_addr  out  ADDR_W  byte address, word-aligned; stable while mem_req=1.
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  32  read data; sampled in the cycle mem_ready=1.
- mem_ready  in  1  access completes in the cycle mem_req=1 and mem_ready=1.
- pc  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; set on illegal instruction, cleared only by reset.

## Operation

Supported instructions (standard MIPS encodings):
- R-type, op 0x00, with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.

Illegal cases, each of which enters HALT:
- Any other opcode or funct.
- Any rs, rt or rd field >= NREGS on an instruction that uses that field.

Datapath rules:
- All arithmetic is 32-bit, wrapping, with no overflow trap.
- Immediates are sign-extended to 32 bits.
- Memory address = (rs + sext(imm))[ADDR_W-1:0], with the low 2 bits forced to 0.
- Writes to r0 are discarded.

States and transitions:
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready, latch IR from mem_rdata and go to DECODE.
- DECODE: read A=R[rs] and B=R[rt]; pc <= pc+4; go to EXEC, or to HALT if illegal.
- EXEC, by instruction:
  - R-type / addi: compute ALU result, go to WB.
  - lw / sw: compute address, go to MEM.
  - beq: if A==B, pc <= pc + (sext(imm)<<2). Pulse retire and go to FETCH.
  - j: pc <= {pc[ADDR_W-1:28], target, 2'b00}, truncated to ADDR_W. Pulse retire and go to FETCH.
- MEM: mem_req=1, mem_we=(sw), mem_wdata=B. On mem_ready:
  - lw latches MDR and goes to WB.
  - sw pulses retire and goes to FETCH.
- WB: write rd (R-type), rt (addi) or MDR into rt (lw). Pulse retire and go to FETCH.
- HALT: halted=1, mem_req=0. PC holds the address of the next instruction after the faulting one, and the state never changes until reset.

## Timing

Reset (on the clock edge with reset=1):
- state=FETCH, pc=RESET_PC, all registers 0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0.
- In the first cycle after reset deasserts, FETCH drives mem_req=1.

Handshake:
- mem_req, mem_we, mem_addr and mem_wdata stay stable until the mem_ready cycle.
- mem_req is 0 in the cycle after acceptance.
- mem_ready while mem_req=0 is ignored.

Latency with zero wait states (mem_ready tied 1), in cycles per instruction:
- beq and j: 3.
- R-type, addi and sw: 4.
- lw: 5.
- Each memory wait cycle adds one cycle.

Other timing rules:
- retire is asserted in the cycle the architectural state update is registered.
- Reset mid-transaction: mem_req drops in the reset cycle. The pending access is abandoned, and a late mem_ready is ignored.
- Back-to-back dependent instructions need no forwarding, because WB completes before the next DECODE.

## Test plan

- Reset, then mem_ready=1 with memory holding addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 → retire pulses at cycles 4, 8, 12 and r3=12. Also run slt on -1 vs 1 → 1.
- sw r3,0x40(r0) then lw r4,0x40(r0) → store with mem_addr=0x40, mem_we=1, mem_wdata=12; r4=12; lw retire 5 cycles after the lw fetch starts.
- Wait states: mem_ready low for 3 cycles on each access → mem_req and mem_addr held stable throughout; add takes 7 cycles.
- beq r1,r1,-1 → pc returns to the beq address (tight loop). j to 0x100 → next fetch at 0x100.
- Illegal opcode 0x3F, and separately (NREGS=8) add r9,… → halted=1, mem_req stays 0, pc = faulting address + 4.
- Assert reset during a waited lw MEM phase → mem_req=0 next cycle, pc=RESET_PC, registers cleared, a late mem_ready is ignored.
